lowx_arbiter: RTL and testbench

LOWX_ARBITER -- requirements
Module: lowx_arbiter

---
 rtl/ceres_param.sv | 30 +++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/lowx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lowx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceres_param.sv
// Shared parameters and types for the lowx memory arbiter.
package ceres_param;

    // Default address and cache-line widths.
    localparam int XLEN_DEF     = 32;
    localparam int BLK_SIZE_DEF = 128;

    // Width of the per-transaction watchdog counter.
    localparam int WDOG_W = 16;

    // Grant-select encoding, also used for the last_grant register.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_REQ_I  = 3'd1,
        ARB_REQ_D  = 3'd2,
        ARB_WAIT_I = 3'd3,
        ARB_WAIT_D = 3'd4,
        ARB_RESP   = 3'd5
    } lowx_arb_state_e;

    // True for either waiting state.
    function automatic logic is_wait(input lowx_arb_state_e s);
        return (s == ARB_WAIT_I) || (s == ARB_WAIT_D);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2
    import ceres_param::*;
(
    input  logic ic_req_i,
    input  logic dc_req_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_sel_o
);

    // Pick a winner; a lone requester wins regardless of history.
    always_comb begin
        gnt_valid_o = ic_req_i | dc_req_i;
        gnt_sel_o   = GNT_I;
        if (ic_req_i && dc_req_i) begin
            gnt_sel_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
        end else if (dc_req_i) begin
            gnt_sel_o = GNT_D;
        end
    end

endmodule

// File: rtl/lowx_arbiter.sv
// Shares one lower-level memory port between the I-cache and the D-cache.
//
// Handshake: requester valid is level-sensitive and sampled only in IDLE; the
// requester holds it until its res_valid, which is a single-cycle pulse.
// mem_req_valid_o is a single-cycle pulse; mem_req_* fields stay stable until
// mem_res_valid_i, which is only honoured while waiting for a response.
module lowx_arbiter
    import ceres_param::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BLK_SIZE    = BLK_SIZE_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // I-cache line fill
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_data_o,
    // D-cache
    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_rw_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    input  logic                dc_req_uncached_i,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_data_o,
    // Shared lower level
    output logic                mem_req_valid_o,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_rw_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    output logic                mem_req_uncached_o,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_data_i,
    // Status
    output logic                timeout_o,
    output logic                busy_o,
    output logic [2:0]          dbg_state_o
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

    lowx_arb_state_e     state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic [WDOG_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [BLK_SIZE-1:0] wdata_q, wdata_d;
    logic                unc_q, unc_d;
    logic [BLK_SIZE-1:0] res_q, res_d;
    logic                timeout_q, timeout_d;

    logic gnt_valid;
    logic gnt_sel;

    rr_arbiter2 u_rr (
        .ic_req_i     (ic_req_valid_i),
        .dc_req_i     (dc_req_valid_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_sel_o    (gnt_sel)
    );

    // Next-state logic: grant and latch in IDLE, pulse request, wait with watchdog, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        unc_d        = unc_q;
        res_d        = res_q;
        timeout_d    = timeout_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    gnt_d = gnt_sel;
                    cnt_d = '0;
                    if (gnt_sel == GNT_D) begin
                        addr_d  = dc_req_addr_i;
                        rw_d    = dc_req_rw_i;
                        wdata_d = dc_req_data_i;
                        unc_d   = dc_req_uncached_i;
                        state_d = ARB_REQ_D;
                    end else begin
                        // Instruction fetches are always cached reads.
                        addr_d  = ic_req_addr_i;
                        rw_d    = 1'b0;
                        wdata_d = '0;
                        unc_d   = 1'b0;
                        state_d = ARB_REQ_I;
                    end
                end
            end
            ARB_REQ_I: begin
                cnt_d   = '0;
                state_d = ARB_WAIT_I;
            end
            ARB_REQ_D: begin
                cnt_d   = '0;
                state_d = ARB_WAIT_D;
            end
            ARB_WAIT_I, ARB_WAIT_D: begin
                // A response arriving on the limit cycle still wins over the watchdog.
                if (mem_res_valid_i) begin
                    res_d   = mem_res_data_i;
                    state_d = ARB_RESP;
                end else if (cnt_q == WDOG_LIMIT) begin
                    res_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + WDOG_W'(1);
                end
            end
            ARB_RESP: begin
                last_grant_d = gnt_q;
                state_d      = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latched-field registers; reset abandons any transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_I;
            gnt_q        <= GNT_I;
            cnt_q        <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            unc_q        <= 1'b0;
            res_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            unc_q        <= unc_d;
            res_q        <= res_d;
            timeout_q    <= timeout_d;
        end
    end

    // Outputs are decoded from the state and the latched registers.
    always_comb begin
        mem_req_valid_o    = (state_q == ARB_REQ_I) || (state_q == ARB_REQ_D);
        mem_req_addr_o     = addr_q;
        mem_req_rw_o       = rw_q;
        mem_req_data_o     = wdata_q;
        mem_req_uncached_o = unc_q;
        ic_res_valid_o     = (state_q == ARB_RESP) && (gnt_q == GNT_I);
        dc_res_valid_o     = (state_q == ARB_RESP) && (gnt_q == GNT_D);
        ic_res_data_o      = ic_res_valid_o ? res_q : '0;
        dc_res_data_o      = dc_res_valid_o ? res_q : '0;
        timeout_o          = timeout_q;
        busy_o             = (state_q != ARB_IDLE);
        dbg_state_o        = state_q;
    end

endmodule

// File: tb/tb_lowx_arbiter.sv
// Directed bench for lowx_arbiter with hand-computed expectations.
module tb_lowx_arbiter;

  localparam int XLEN = 32;
  localparam int BLK  = 128;
  localparam int TMO  = 8;

  // state encodings as seen on dbg_state_o
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_I  = 3'd1;
  localparam logic [2:0] S_REQ_D  = 3'd2;
  localparam logic [2:0] S_WAIT_D = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ic_req_valid_i = 1'b0;
  logic [XLEN-1:0] ic_req_addr_i = '0;
  logic            ic_res_valid_o;
  logic [BLK-1:0]  ic_res_data_o;
  logic            dc_req_valid_i = 1'b0;
  logic [XLEN-1:0] dc_req_addr_i = '0;
  logic            dc_req_rw_i = 1'b0;
  logic [BLK-1:0]  dc_req_data_i = '0;
  logic            dc_req_uncached_i = 1'b0;
  logic            dc_res_valid_o;
  logic [BLK-1:0]  dc_res_data_o;
  logic            mem_req_valid_o;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_req_rw_o;
  logic [BLK-1:0]  mem_req_data_o;
  logic            mem_req_uncached_o;
  logic            mem_res_valid_i = 1'b0;
  logic [BLK-1:0]  mem_res_data_i = '0;
  logic            timeout_o;
  logic            busy_o;
  logic [2:0]      dbg_state_o;

  lowx_arbiter #(
    .XLEN        (XLEN),
    .BLK_SIZE    (BLK),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ic_req_valid_i     (ic_req_valid_i),
    .ic_req_addr_i      (ic_req_addr_i),
    .ic_res_valid_o     (ic_res_valid_o),
    .ic_res_data_o      (ic_res_data_o),
    .dc_req_valid_i     (dc_req_valid_i),
    .dc_req_addr_i      (dc_req_addr_i),
    .dc_req_rw_i        (dc_req_rw_i),
    .dc_req_data_i      (dc_req_data_i),
    .dc_req_uncached_i  (dc_req_uncached_i),
    .dc_res_valid_o     (dc_res_valid_o),
    .dc_res_data_o      (dc_res_data_o),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_req_rw_o       (mem_req_rw_o),
    .mem_req_data_o     (mem_req_data_o),
    .mem_req_uncached_o (mem_req_uncached_o),
    .mem_res_valid_i    (mem_res_valid_i),
    .mem_res_data_i     (mem_res_data_i),
    .timeout_o          (timeout_o),
    .busy_o             (busy_o),
    .dbg_state_o        (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [BLK-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance until mem_req_valid_o is seen, bounded
  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_req_valid_o === 1'b1) seen = 1'b1;
    end
    check("req_seen", seen, 1);
  endtask

  // from REQ: spend n WAIT cycles, answer on the last one; ends in RESP
  task automatic serve(input int n, input logic [BLK-1:0] d);
    for (int i = 0; i < n; i++) begin
      tick();
      check("no_req_in_wait", mem_req_valid_o, 0);
    end
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = d;
    exp_q.push_back(d);
    tick();
    mem_res_valid_i = 1'b0;
    mem_res_data_i  = '0;
  endtask

  // in RESP: the granted side pulses with the expected data, the other stays low
  task automatic check_resp(input bit is_d);
    logic [BLK-1:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("resp_state", dbg_state_o, S_RESP);
    if (is_d) begin
      check("dc_res_valid", dc_res_valid_o, 1);
      check("dc_res_data", dc_res_data_o, e);
      check("ic_res_quiet", ic_res_valid_o, 0);
    end else begin
      check("ic_res_valid", ic_res_valid_o, 1);
      check("ic_res_data", ic_res_data_o, e);
      check("dc_res_quiet", dc_res_valid_o, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_state"}, dbg_state_o, S_IDLE);
    check({tag, "_ic_res"}, ic_res_valid_o, 0);
    check({tag, "_dc_res"}, dc_res_valid_o, 0);
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "time limit reached");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [BLK-1:0] a5;
    a5 = {16{8'hA5}};

    // reset values, checked while reset is held
    #2;
    check("rst_state", dbg_state_o, S_IDLE);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_mem_req_valid", mem_req_valid_o, 0);
    check("rst_mem_req_addr", mem_req_addr_o, 0);
    check("rst_mem_req_data", mem_req_data_o, 0);
    check("rst_ic_res", ic_res_valid_o, 0);
    check("rst_dc_res", dc_res_valid_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single I-cache fill
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 32'h8000_0040;
    wait_req();
    check("i1_state", dbg_state_o, S_REQ_I);
    check("i1_addr", mem_req_addr_o, 32'h8000_0040);
    check("i1_rw", mem_req_rw_o, 0);
    check("i1_unc", mem_req_uncached_o, 0);
    check("i1_data", mem_req_data_o, 0);
    check("i1_busy", busy_o, 1);
    check("i1_dc_quiet", dc_res_valid_o, 0);
    serve(3, a5);
    check_resp(1'b0);
    ic_req_valid_i = 1'b0;
    tick();
    check_idle("i1_after");

    // tie right after a fresh reset: D, then I, then D again
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 32'h0000_1000;
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 32'h0000_2000;
    dc_req_rw_i    = 1'b0;
    dc_req_data_i  = '0;
    dc_req_uncached_i = 1'b0;
    wait_req();
    check("tie1_state", dbg_state_o, S_REQ_D);
    check("tie1_addr", mem_req_addr_o, 32'h0000_2000);
    serve(2, 128'h1111);
    check_resp(1'b1);
    dc_req_valid_i = 1'b0;
    tick();
    check_idle("tie1_after");
    wait_req();
    check("tie2_state", dbg_state_o, S_REQ_I);
    check("tie2_addr", mem_req_addr_o, 32'h0000_1000);
    serve(1, 128'h2222);
    check_resp(1'b0);
    dc_req_valid_i = 1'b1;
    tick();
    check("tie3_idle", dbg_state_o, S_IDLE);
    wait_req();
    check("tie3_state", dbg_state_o, S_REQ_D);
    check("tie3_addr", mem_req_addr_o, 32'h0000_2000);
    serve(1, 128'h3333);
    check_resp(1'b1);
    ic_req_valid_i = 1'b0;
    dc_req_valid_i = 1'b0;
    tick();
    check_idle("tie3_after");

    // D uncached store; valid dropped after grant, fields must hold
    dc_req_valid_i    = 1'b1;
    dc_req_addr_i     = 32'h2000_0000;
    dc_req_rw_i       = 1'b1;
    dc_req_data_i     = 128'h1234;
    dc_req_uncached_i = 1'b1;
    wait_req();
    dc_req_valid_i    = 1'b0;
    dc_req_addr_i     = 32'hFFFF_FFFF;
    dc_req_rw_i       = 1'b0;
    dc_req_data_i     = '1;
    dc_req_uncached_i = 1'b0;
    check("st_addr", mem_req_addr_o, 32'h2000_0000);
    check("st_rw", mem_req_rw_o, 1);
    check("st_data", mem_req_data_o, 128'h1234);
    check("st_unc", mem_req_uncached_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_addr", mem_req_addr_o, 32'h2000_0000);
      check("st_hold_rw", mem_req_rw_o, 1);
      check("st_hold_data", mem_req_data_o, 128'h1234);
      check("st_hold_unc", mem_req_uncached_o, 1);
      check("st_hold_valid", mem_req_valid_o, 0);
    end
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = 128'hBEEF;
    exp_q.push_back(128'hBEEF);
    tick();
    mem_res_valid_i = 1'b0;
    mem_res_data_i  = '0;
    check_resp(1'b1);
    tick();
    check_idle("st_after");

    // watchdog: no answer, limit after 8 WAIT cycles
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 32'h0000_0100;
    wait_req();
    ic_req_valid_i = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      tick();
      check("wd_no_timeout", timeout_o, 0);
      check("wd_no_res", ic_res_valid_o, 0);
    end
    tick();
    check("wd_timeout", timeout_o, 1);
    check("wd_res_valid", ic_res_valid_o, 1);
    check("wd_res_data", ic_res_data_o, 0);
    check("wd_dc_quiet", dc_res_valid_o, 0);
    tick();
    check("wd_sticky", timeout_o, 1);
    check_idle("wd_after");
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 32'h0000_0200;
    dc_req_rw_i    = 1'b0;
    wait_req();
    check("wd_next_addr", mem_req_addr_o, 32'h0000_0200);
    serve(3, 128'h5A5A);
    check_resp(1'b1);
    dc_req_valid_i = 1'b0;
    tick();
    check("wd_next_sticky", timeout_o, 1);

    // reset during WAIT_D abandons the transaction
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 32'h3000_0000;
    wait_req();
    tick();
    check("rw_state", dbg_state_o, S_WAIT_D);
    #2;
    rst_n = 1'b0;
    dc_req_valid_i = 1'b0;
    #1;
    check("rw_busy", busy_o, 0);
    check("rw_timeout", timeout_o, 0);
    check("rw_addr", mem_req_addr_o, 0);
    check("rw_state0", dbg_state_o, S_IDLE);
    check("rw_mem_valid", mem_req_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = 128'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_res_valid_i = 1'b0;
      mem_res_data_i  = '0;
      check_idle("rw_late");
    end

    // spurious response in IDLE
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = 128'hCAFE;
    tick();
    mem_res_valid_i = 1'b0;
    mem_res_data_i  = '0;
    check_idle("spur");
    check("spur_data", ic_res_data_o, 0);
    tick();
    check_idle("spur2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
